// File: rtl/fan_level_timer.sv
// Kitchen-hood fan-level controller: level FSM, one-shot boost countdown,
// cumulative mm:ss run timer and packed BCD display word.
module fan_level_timer #(
    parameter int unsigned LEVELS         = 3,
    parameter int unsigned BOOST_SEC      = 60,
    parameter int unsigned FALLBACK_LEVEL = 2,
    parameter int unsigned BOOST_ONCE     = 1,
    parameter int unsigned CUM_MAX_MIN    = 59
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic              req_valid,
    input  logic [2:0]        req_level,
    input  logic              boost_rearm,
    output logic [2:0]        level,
    output logic [LEVELS-1:0] led,
    output logic              boost_active,
    output logic              boost_used,
    output logic [31:0]       time_bcd
);

    localparam int unsigned CD_W  = 13;
    localparam int unsigned MIN_W = 7;
    localparam int unsigned SEC_W = 6;

    typedef enum logic [1:0] {
        ST_STANDBY,
        ST_RUN,
        ST_BOOST
    } state_t;

    state_t            state, state_nx;
    logic [2:0]        level_nx;
    logic [CD_W-1:0]   cd, cd_nx;
    logic [SEC_W-1:0]  cum_sec, cum_sec_nx;
    logic [MIN_W-1:0]  cum_min, cum_min_nx;
    logic              used_nx;
    logic [MIN_W-1:0]  disp_min, disp_sec;
    logic [31:0]       time_nx;

    function automatic logic [7:0] to_bcd(input logic [MIN_W-1:0] v);
        to_bcd = {4'(v / MIN_W'(10)), 4'(v % MIN_W'(10))};
    endfunction

    // State and counter registers; boost_active mirrors the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_STANDBY;
            level        <= 3'd0;
            cd           <= '0;
            cum_sec      <= '0;
            cum_min      <= '0;
            boost_used   <= 1'b0;
            boost_active <= 1'b0;
            time_bcd     <= 32'h00F0_0F00;
        end else begin
            state        <= state_nx;
            level        <= level_nx;
            cd           <= cd_nx;
            cum_sec      <= cum_sec_nx;
            cum_min      <= cum_min_nx;
            boost_used   <= used_nx;
            boost_active <= (state_nx == ST_BOOST);
            time_bcd     <= time_nx;
        end
    end

    // Next state: timer and countdown first, then a request overrides the countdown.
    always_comb begin
        state_nx   = state;
        level_nx   = level;
        cd_nx      = cd;
        cum_sec_nx = cum_sec;
        cum_min_nx = cum_min;
        used_nx    = boost_used;

        if (tick_1hz && (level != 3'd0)) begin
            if (cum_sec == SEC_W'(59)) begin
                cum_sec_nx = '0;
                cum_min_nx = (cum_min == MIN_W'(CUM_MAX_MIN)) ? '0 : cum_min + MIN_W'(1);
            end else begin
                cum_sec_nx = cum_sec + SEC_W'(1);
            end
        end

        if ((state == ST_BOOST) && tick_1hz) begin
            if (cd == CD_W'(1)) begin
                state_nx = ST_RUN;
                level_nx = 3'(FALLBACK_LEVEL);
                cd_nx    = '0;
            end else begin
                cd_nx = cd - CD_W'(1);
            end
        end

        if (boost_rearm) begin
            used_nx = 1'b0;
        end

        if (req_valid) begin
            if (req_level == 3'd0) begin
                state_nx = ST_STANDBY;
                level_nx = 3'd0;
                cd_nx    = '0;
            end else if (req_level < 3'(LEVELS)) begin
                state_nx = ST_RUN;
                level_nx = req_level;
                cd_nx    = '0;
            end else if ((req_level == 3'(LEVELS)) && (state != ST_BOOST) &&
                         ((BOOST_ONCE == 0) || !boost_used)) begin
                state_nx = ST_BOOST;
                level_nx = 3'(LEVELS);
                cd_nx    = CD_W'(BOOST_SEC);
                if (BOOST_ONCE != 0) begin
                    used_nx = 1'b1;
                end
            end
        end
    end

    // Display source: countdown while boosting, cumulative otherwise.
    always_comb begin
        if (state == ST_BOOST) begin
            disp_min = MIN_W'(cd / CD_W'(60));
            disp_sec = MIN_W'(cd % CD_W'(60));
        end else begin
            disp_min = cum_min;
            disp_sec = MIN_W'(cum_sec);
        end
        time_nx = {8'h00, 4'hF, to_bcd(disp_min), 4'hF, to_bcd(disp_sec)};
    end

    always_comb begin
        led = '0;
        for (int i = 0; i < int'(LEVELS); i++) begin
            if (level == 3'(i + 1)) begin
                led[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fan_level_timer.sv
// Directed bench for fan_level_timer: vector table plus async-reset and
// registered-latency sequences.
module tb_fan_level_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick_1hz = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_level = 3'd0;
    logic        boost_rearm = 1'b0;
    logic [2:0]  level;
    logic [2:0]  led;
    logic        boost_active;
    logic        boost_used;
    logic [31:0] time_bcd;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic        v;
        logic [2:0]  rl;
        logic        t;
        logic        r;
        int          n;
        logic [2:0]  lvl;
        logic [2:0]  led;
        logic        act;
        logic        used;
        logic [31:0] bcd;
    } vec_t;

    vec_t vq[$];

    fan_level_timer dut (
        .clk          (clk),
        .rst          (rst),
        .tick_1hz     (tick_1hz),
        .req_valid    (req_valid),
        .req_level    (req_level),
        .boost_rearm  (boost_rearm),
        .level        (level),
        .led          (led),
        .boost_active (boost_active),
        .boost_used   (boost_used),
        .time_bcd     (time_bcd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic v, input logic [2:0] rl, input logic t, input logic r,
                       input int n, input logic [2:0] lvl, input logic [2:0] l,
                       input logic act, input logic used, input logic [31:0] bcd);
        vec_t e;
        e = '{v, rl, t, r, n, lvl, l, act, used, bcd};
        vq.push_back(e);
    endtask

    task automatic cyc(input logic v, input logic [2:0] rl, input logic t, input logic r);
        req_valid   = v;
        req_level   = rl;
        tick_1hz    = t;
        boost_rearm = r;
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
        req_level   = 3'd0;
        tick_1hz    = 1'b0;
        boost_rearm = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [2:0] lvl, input logic [2:0] l,
                             input logic act, input logic used, input logic [31:0] bcd);
        check({tag, ".level"}, 32'(level), 32'(lvl));
        check({tag, ".led"}, 32'(led), 32'(l));
        check({tag, ".boost_active"}, 32'(boost_active), 32'(act));
        check({tag, ".boost_used"}, 32'(boost_used), 32'(used));
        check({tag, ".time_bcd"}, time_bcd, bcd);
    endtask

    initial begin
        //  v  rl   t  r  n     lvl  led     act used bcd
        add(1, 1, 0, 0, 1,    1, 3'b001, 0, 0, 32'h00F00F00);
        add(0, 0, 1, 0, 61,   1, 3'b001, 0, 0, 32'h00F01F01);
        add(1, 0, 0, 0, 1,    0, 3'b000, 0, 0, 32'h00F01F01);
        add(0, 0, 1, 0, 5,    0, 3'b000, 0, 0, 32'h00F01F01);
        add(1, 3, 0, 0, 1,    3, 3'b100, 1, 1, 32'h00F01F00);
        add(0, 0, 1, 0, 1,    3, 3'b100, 1, 1, 32'h00F00F59);
        add(0, 0, 1, 0, 59,   2, 3'b010, 0, 1, 32'h00F02F01);
        add(1, 3, 0, 0, 1,    2, 3'b010, 0, 1, 32'h00F02F01);
        add(0, 0, 0, 1, 1,    2, 3'b010, 0, 0, 32'h00F02F01);
        add(1, 3, 0, 0, 1,    3, 3'b100, 1, 1, 32'h00F01F00);
        add(0, 0, 1, 0, 30,   3, 3'b100, 1, 1, 32'h00F00F30);
        add(1, 1, 0, 0, 1,    1, 3'b001, 0, 1, 32'h00F02F31);
        add(1, 3, 0, 0, 1,    1, 3'b001, 0, 1, 32'h00F02F31);
        add(1, 0, 0, 0, 1,    0, 3'b000, 0, 1, 32'h00F02F31);
        add(1, 1, 1, 0, 1,    1, 3'b001, 0, 1, 32'h00F02F31);
        add(0, 0, 1, 0, 3448, 1, 3'b001, 0, 1, 32'h00F59F59);
        add(0, 0, 1, 0, 1,    1, 3'b001, 0, 1, 32'h00F00F00);
        add(0, 0, 0, 1, 1,    1, 3'b001, 0, 0, 32'h00F00F00);
        add(1, 3, 1, 0, 1,    3, 3'b100, 1, 1, 32'h00F01F00);
        add(0, 0, 1, 0, 10,   3, 3'b100, 1, 1, 32'h00F00F50);
        add(0, 0, 0, 1, 1,    3, 3'b100, 1, 0, 32'h00F00F50);
        add(1, 0, 0, 0, 1,    0, 3'b000, 0, 0, 32'h00F00F11);
        add(1, 3, 0, 1, 1,    3, 3'b100, 1, 1, 32'h00F01F00);
        add(1, 4, 0, 0, 1,    3, 3'b100, 1, 1, 32'h00F01F00);

        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 3'd0, 3'b000, 1'b0, 1'b0, 32'h00F00F00);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        foreach (vq[i]) begin
            for (int k = 0; k < vq[i].n; k++) cyc(vq[i].v, vq[i].rl, vq[i].t, vq[i].r);
            repeat (2) cyc(1'b0, 3'd0, 1'b0, 1'b0);
            check_all($sformatf("vec%0d", i), vq[i].lvl, vq[i].led, vq[i].act,
                      vq[i].used, vq[i].bcd);
        end

        // Boost countdown down to 00:17, then asynchronous reset mid-cycle.
        repeat (43) cyc(1'b0, 3'd0, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 3'd0, 1'b0, 1'b0);
        check("boost_0017", time_bcd, 32'h00F00F17);
        #2;
        rst = 1'b0;
        #1;
        check_all("async_rst", 3'd0, 3'b000, 1'b0, 1'b0, 32'h00F00F00);
        @(posedge clk);
        #3;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Boost available again; state visible next edge, display one edge later.
        cyc(1'b1, 3'd3, 1'b0, 1'b0);
        check("post_rst.level", 32'(level), 32'd3);
        check("post_rst.boost_active", 32'(boost_active), 32'd1);
        check("post_rst.bcd_lag", time_bcd, 32'h00F00F00);
        cyc(1'b0, 3'd0, 1'b0, 1'b0);
        check("post_rst.bcd", time_bcd, 32'h00F01F00);
        check("post_rst.used", 32'(boost_used), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fan_level_timer.md
Name: fan_level_timer

Overview:
- Parametrised fan-level controller for the kitchen hood.
- Accepts fan-level requests and tracks cumulative run time in mm:ss.
- Runs a one-shot boost (hurricane) countdown that falls back automatically to a configurable level when it expires.
- Sits between the mode-select FSM and the time display driver, and drives the level LEDs and a packed BCD time word.

Parameters:
- LEVELS, 3, number of fan levels including boost; valid 2..7. Levels 1..LEVELS-1 are normal; level LEVELS is boost.
- BOOST_SEC, 60, boost countdown length in seconds; valid 1..5999.
- FALLBACK_LEVEL, 2, level entered when boost expires; valid 1..LEVELS-1.
- BOOST_ONCE, 1, 1 = boost usable once until rst or boost_rearm; 0 = boost always available.
- CUM_MAX_MIN, 59, cumulative minute wrap point; valid 1..99.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- tick_1hz  in  1  single-cycle 1 Hz enable pulse.
- req_valid  in  1  single-cycle level-request strobe.
- req_level  in  3  requested level: 0 = standby, 1..LEVELS-1 = normal, LEVELS = boost.
- boost_rearm  in  1  pulse; clears boost_used.
- level  out  3  current fan level.
- led  out  LEVELS  one-hot level LEDs; bit i-1 lit for level i; all zero in standby.
- boost_active  out  1  high while in BOOST.
- boost_used  out  1  boost consumed.
- time_bcd  out  32  packed display word {4'h0,4'h0,4'hF,min_tens,min_ones,4'hF,sec_tens,sec_ones}.

Behaviour:
Reset (asynchronous, rst=0):
- State STANDBY; level=0, led=0, boost_active=0, boost_used=0.
- Cumulative counter 00:00, countdown 0.
- time_bcd=32'h00F00F00.

States:
- STANDBY (level 0).
- RUN (level 1..LEVELS-1).
- BOOST (level LEVELS).
- All transitions are registered and visible on the cycle after the triggering edge.

Requests (evaluated only when req_valid=1):
- req_level=0: go to STANDBY from any state. If in BOOST, the countdown clears to 0.
- req_level 1..LEVELS-1: go to RUN at that level from any state. If in BOOST, the boost is aborted and the countdown clears; boost_used stays set.
- req_level=LEVELS:
  - Accepted only if not in BOOST and (BOOST_ONCE=0 or boost_used=0).
  - On acceptance: enter BOOST, load countdown=BOOST_SEC, and set boost_used on the same edge (only if BOOST_ONCE=1).
  - Otherwise the request is ignored and the state is unchanged.
- req_level>LEVELS: ignored.

Countdown:
- In BOOST, each tick_1hz decrements the countdown.
- A tick with countdown=1 ends the boost: state goes to RUN at FALLBACK_LEVEL, countdown=0, boost_active=0, all on the same edge.

Cumulative timer:
- On tick_1hz, increments when the level before the edge is nonzero (RUN or BOOST); it holds in STANDBY.
- sec wraps 59->0 and carries into min; min wraps CUM_MAX_MIN->0.
- Never cleared except by rst.

Simultaneous events:
- req_valid and tick_1hz in the same cycle: the cumulative timer uses the pre-request level, and the request then overrides any countdown action.
- A boost request accepted together with a tick loads BOOST_SEC without decrementing.
- boost_rearm together with an accepted boost request: the request wins, and boost_used ends at 1.
- boost_rearm during BOOST clears boost_used but does not affect the running countdown.

time_bcd:
- Shows the countdown, split into min and sec, while in BOOST; shows the cumulative value otherwise.
- Registered: updates one cycle after the counter or state change.
- Digits are produced by binary-to-BCD conversion, with each digit in 0..9.

led:
- Derived combinationally from level; always one-hot or zero.

Test Plan:
- Reset, request level 1, apply 61 ticks -> level=1, led=3'b001, time_bcd=32'h00F01F01. Then request 0 and apply 5 ticks -> time_bcd unchanged, led=0.
- Request level 3 (BOOST_SEC=60) -> boost_active=1, time_bcd=32'h00F01F00. After 1 tick -> 32'h00F00F59. After 59 more ticks -> level=2, boost_active=0, boost_used=1, and the cumulative display has advanced by 60 s.
- After boost expiry, request level 3 again -> ignored, level stays 2. Pulse boost_rearm, request 3 -> BOOST with countdown reloaded to 01:00.
- During BOOST at 00:30, request level 1 -> level=1, boost_active=0, display shows cumulative. A later boost request is rejected (BOOST_ONCE=1).
- CUM_MAX_MIN=59 with cumulative at 59:59 in RUN, then 1 tick -> time_bcd=32'h00F00F00. req_valid with req_level=1 coincident with a tick from STANDBY -> cumulative not incremented on that edge.
- Assert rst mid-BOOST at 00:17 -> all outputs return to reset values asynchronously. After release, boost is available again.
